gray_mem_arbiter: RTL and testbench



---
 rtl/gray_mem_arbiter_pkg.sv | 16 +
 rtl/gray_mem_arbiter_if.sv | 41 ++++
 rtl/gray_mem_arbiter.sv | 113 +++++++++++
 tb/tb_gray_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_mem_arbiter_pkg.sv
// Shared types and constants for the LBP gray-memory datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbp_pkg;

  localparam int LBP_AW        = 14;  // {row[6:0], col[6:0]} for a 128x128 image
  localparam int LBP_DW        = 8;   // gray pixel width
  localparam int LBP_WIN_READS = 9;   // one 3x3 window: center plus 8 neighbours

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/gray_mem_arbiter_if.sv
// Bundle of the two requester ports and the gray memory read port.
// Latency: n/a (wiring only).
// Backpressure: requesters stall while their own grant is low.
interface gray_mem_arbiter_if
  import lbp_pkg::*;
#(
  parameter int AW = LBP_AW,
  parameter int DW = LBP_DW
);

  // memory side
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic          gray_req;
  logic [AW-1:0] gray_addr;

  // requester side
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          gnt0;
  logic          gnt1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          ready0;
  logic          ready1;

  // arbiter view
  modport slave (
    input  gray_ready, gray_data, req0, req1, addr0, addr1,
    output gray_req, gray_addr, gnt0, gnt1, data0, data1, ready0, ready1
  );

  // environment view (requesters plus memory)
  modport master (
    output gray_ready, gray_data, req0, req1, addr0, addr1,
    input  gray_req, gray_addr, gnt0, gnt1, data0, data1, ready0, ready1
  );

endinterface

// File: rtl/gray_mem_arbiter.sv
// Round-robin burst arbiter for two requesters sharing the gray memory read port.
// Latency: grant one cycle after request from IDLE; zero-cycle handover; read data same cycle.
// Backpressure: a requester whose grant is low (never granted or preempted) holds its address and stalls.
module gray_mem_arbiter
  import lbp_pkg::*;
#(
  parameter int AW        = LBP_AW,
  parameter int DW        = LBP_DW,
  parameter int MAX_BURST = LBP_WIN_READS  // 0 disables preemption
) (
  input  logic               clk,
  input  logic               reset,
  gray_mem_arbiter_if.slave  bus
);

  // Counter just wide enough for MAX_BURST-1; at least one bit so MAX_BURST=0 still elaborates.
  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;

  arb_state_t    r_state;
  arb_state_t    w_next_state;
  logic          r_last;       // side granted most recently; 1 after reset so side 0 wins the first tie
  logic          r_rdy_seen;   // sticky copy of gray_ready
  logic [CW-1:0] r_burst_cnt;

  logic          w_cap_hit;
  logic [AW-1:0] w_addr_mux;
  logic [DW-1:0] w_rd_data;

  // Holder of the grant has had its full share once the counter reaches the last slot.
  assign w_cap_hit = (MAX_BURST != 0) && (r_burst_cnt == CNT_LAST);

  // Next-state selection: a drop always wins over a preempt, ties go to the side not served last.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_rdy_seen) begin
          if (bus.req0 && bus.req1) begin
            w_next_state = r_last ? GNT0 : GNT1;
          end else if (bus.req0) begin
            w_next_state = GNT0;
          end else if (bus.req1) begin
            w_next_state = GNT1;
          end
        end
      end
      GNT0: begin
        if (!bus.req0) begin
          w_next_state = bus.req1 ? GNT1 : IDLE;
        end else if (w_cap_hit && bus.req1) begin
          w_next_state = GNT1;
        end
      end
      GNT1: begin
        if (!bus.req1) begin
          w_next_state = bus.req0 ? GNT0 : IDLE;
        end else if (w_cap_hit && bus.req0) begin
          w_next_state = GNT0;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset clears grants immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fairness bookkeeping: restart the burst count on every grant entry, saturate while holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
    end else if ((w_next_state == GNT0) && (r_state != GNT0)) begin
      r_last      <= 1'b0;
      r_burst_cnt <= '0;
    end else if ((w_next_state == GNT1) && (r_state != GNT1)) begin
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
    end else if ((w_next_state == r_state) && (r_state != IDLE) && (r_burst_cnt != CNT_LAST)) begin
      r_burst_cnt <= r_burst_cnt + CW'(1);
    end
  end

  // Latch memory-ready once; it never drops until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy_seen <= 1'b0;
    end else if (bus.gray_ready) begin
      r_rdy_seen <= 1'b1;
    end
  end

  // Address defaults to requester 0 so the bus never floats to X while idle.
  assign w_addr_mux = (r_state == GNT1) ? bus.addr1 : bus.addr0;
  assign w_rd_data  = bus.gray_data;

  assign bus.gnt0      = (r_state == GNT0);
  assign bus.gnt1      = (r_state == GNT1);
  assign bus.gray_req  = ((r_state == GNT0) && bus.req0) || ((r_state == GNT1) && bus.req1);
  assign bus.gray_addr = w_addr_mux;
  assign bus.data0     = w_rd_data;
  assign bus.data1     = w_rd_data;
  assign bus.ready0    = r_rdy_seen;
  assign bus.ready1    = r_rdy_seen;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Scoreboard bench for gray_mem_arbiter: directed per-cycle vectors with hand-derived grants.
// Latency: expected entries are tagged with the cycle they apply to.
// Backpressure: n/a (bench drives requests directly).
module tb_gray_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  typedef struct {
    int            cyc;
    logic          g0;
    logic          g1;
    logic          rq;
    logic          rdy;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_err;
  exp_t sb[$];
  logic [AW-1:0] win [9];

  gray_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  gray_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // gray memory model: combinational read
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  assign bus.gray_data = mem_f(bus.gray_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // one bench cycle: drive inputs, push what the DUT must show during this cycle
  task automatic step(input logic r0, input logic r1, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic rdy,
                      input logic eg0, input logic eg1, input logic erdy);
    exp_t e;
    @(posedge clk);
    #1;
    bus.req0       = r0;
    bus.req1       = r1;
    bus.addr0      = a0;
    bus.addr1      = a1;
    bus.gray_ready = rdy;
    e.cyc  = cyc;
    e.g0   = eg0;
    e.g1   = eg1;
    e.rq   = (eg0 & r0) | (eg1 & r1);
    e.rdy  = erdy;
    e.addr = eg1 ? a1 : a0;
    e.dat  = mem_f(e.addr);
    sb.push_back(e);
  endtask

  // reset-value checks while reset is held, then release mid-cycle
  task automatic hold_release();
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_gray_req", 32'(bus.gray_req), 32'd0);
    chk("rst_gray_addr", 32'(bus.gray_addr), 32'(bus.addr0));
    chk("rst_ready0", 32'(bus.ready0), 32'd0);
    chk("rst_ready1", 32'(bus.ready1), 32'd0);
    @(posedge clk);
    #1;
    bus.req0       = 1'b0;
    bus.req1       = 1'b0;
    bus.gray_ready = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    bus.req0       = 1'b0;
    bus.req1       = 1'b0;
    bus.addr0      = 14'h0155;
    bus.addr1      = 14'h02AA;
    bus.gray_ready = 1'b0;
    hold_release();
  endtask

  // monitor: compare every expected entry in the cycle it belongs to
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("excl_gnt", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_stale entry_cycle=%0d now=%0d", e.cyc, cyc);
        end else begin
          chk("gnt0", 32'(bus.gnt0), 32'(e.g0));
          chk("gnt1", 32'(bus.gnt1), 32'(e.g1));
          chk("gray_req", 32'(bus.gray_req), 32'(e.rq));
          chk("gray_addr", 32'(bus.gray_addr), 32'(e.addr));
          chk("ready0", 32'(bus.ready0), 32'(e.rdy));
          chk("ready1", 32'(bus.ready1), 32'(e.rdy));
          if (e.g0) chk("data0", 32'(bus.data0), 32'(e.dat));
          if (e.g1) chk("data1", 32'(bus.data1), 32'(e.dat));
        end
      end
    end
  end

  initial begin
    cyc            = 0;
    n_checks       = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.req0       = 1'b0;
    bus.req1       = 1'b0;
    bus.addr0      = '0;
    bus.addr1      = '0;
    bus.gray_ready = 1'b0;
    // 3x3 window centred at (1,1): center first, then the 8 neighbours
    win[0] = 14'd129; win[1] = 14'd0;   win[2] = 14'd1;
    win[3] = 14'd2;   win[4] = 14'd130; win[5] = 14'd258;
    win[6] = 14'd257; win[7] = 14'd256; win[8] = 14'd128;

    do_reset();

    // window burst: ready in cycle 2, request from cycle 3, one requester never preempted
    step(1'b0, 1'b0, win[0], 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, win[0], 14'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, win[0], 14'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, win[k], 14'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, win[8], 14'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'd0, 14'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // reset restores last=1: first tie to side 0, next tie to side 1, zero-cycle handover
    do_reset();
    step(1'b0, 1'b0, 14'h0010, 14'h0020, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 14'h0010, 14'h0020, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'h0010, 14'h0020, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 14'h0010, 14'h0020, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 14'h0010, 14'h0020, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 14'h0010, 14'h0020, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'h0010, 14'h0020, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'h0010, 14'h0020, 1'b1, 1'b0, 1'b0, 1'b1);

    // both held: last=0 so side 1 first, then alternating 9-cycle runs
    for (int k = 1; k <= 29; k++) begin
      logic g1_run;
      g1_run = (((k - 2) / 9) % 2) == 0;
      step(1'b1, 1'b1, 14'(14'h0100 + k), 14'(14'h0200 + k), 1'b1,
           (k != 1) && !g1_run, (k != 1) && g1_run, 1'b1);
    end
    step(1'b0, 1'b0, 14'h0100, 14'h0200, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'h0100, 14'h0200, 1'b1, 1'b0, 1'b0, 1'b1);

    // drop coincides with the cap slot: clean handover, new burst count starts at 0
    step(1'b1, 1'b0, 14'h03A5, 14'h01C3, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 14'h03A5, 14'h01C3, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 14'h03A5, 14'h01C3, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 14'h03A5, 14'h01C3, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 14'h03A5, 14'h01C3, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 14'h03A5, 14'h01C3, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'h03A5, 14'h01C3, 1'b1, 1'b0, 1'b0, 1'b1);

    // request before memory ready: no grant until the latched flag is set
    do_reset();
    step(1'b1, 1'b0, 14'h0777, 14'h0888, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 14'h0777, 14'h0888, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 14'h0777, 14'h0888, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 14'h0777, 14'h0888, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 14'h0777, 14'h0888, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 14'h0777, 14'h0888, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 14'h0777, 14'h0888, 1'b1, 1'b0, 1'b1, 1'b1);

    // reset mid-burst in GNT1: grant and read enable fall without a clock edge
    @(posedge clk);
    #1;
    chk("pre_rst_gnt1", 32'(bus.gnt1), 32'd1);
    chk("pre_rst_gray_req", 32'(bus.gray_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_gnt1", 32'(bus.gnt1), 32'd0);
    chk("async_gnt0", 32'(bus.gnt0), 32'd0);
    chk("async_gray_req", 32'(bus.gray_req), 32'd0);
    hold_release();

    // after release: IDLE with last=1, so a tie goes to side 0
    step(1'b0, 1'b0, 14'h0101, 14'h0202, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 14'h0101, 14'h0202, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 14'h0101, 14'h0202, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'h0101, 14'h0202, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 14'h0101, 14'h0202, 1'b1, 1'b0, 1'b0, 1'b1);

    // let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL sb_drain left=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
